// File: rtl/m_spi_burst_ctrl_if.sv
// Register-port and message-buffer bus between m_spi_burst_ctrl and its neighbours.
// master = burst controller side, slave = SPI master core plus buffers.
interface m_spi_burst_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] tx_addr;
    logic [DATA_WIDTH-1:0] tx_byte;
    logic                  rx_we;
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  I_TX_EN;
    logic [2:0]            I_WADDR;
    logic [DATA_WIDTH-1:0] I_WDATA;
    logic                  I_RX_EN;
    logic [2:0]            I_RADDR;
    logic [DATA_WIDTH-1:0] O_RDATA;

    modport master (
        output tx_addr, rx_we, rx_addr, rx_byte,
        output I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR,
        input  tx_byte, O_RDATA
    );
    modport slave (
        input  tx_addr, rx_we, rx_addr, rx_byte,
        input  I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR,
        output tx_byte, O_RDATA
    );
endinterface

// File: rtl/m_spi_burst_ctrl.sv
// Length-controlled full-duplex SPI burst sequencer over the SPI master register port.
// Optional macro SPI_BURST_TIMEOUT_EN adds a status-poll timeout that sets err.
module m_spi_burst_ctrl #(
    parameter int          DATA_WIDTH  = 8,
    parameter int          MAX_LEN     = 64,
    parameter logic [2:0]  ADDR_RXDATA = 3'd0,
    parameter logic [2:0]  ADDR_TXDATA = 3'd1,
    parameter logic [2:0]  ADDR_STATUS = 3'd2,
    parameter logic [2:0]  ADDR_SSMASK = 3'd4,
    parameter int          TRDY_BIT    = 5,
    parameter int          RRDY_BIT    = 7,
    parameter logic [15:0] TIMEOUT     = 16'd50000
) (
    input  logic                I_CLK,
    input  logic                I_RESET,
    input  logic                start,
    input  logic [6:0]          len,
    output logic                busy,
    output logic                done,
    output logic                err,
    m_spi_burst_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ZERO, S_SEL, S_FETCH, S_FETCH_W, S_PT_RD, S_PT_CHK, S_WR_TX,
        S_PR_RD, S_PR_CHK, S_RX_RD, S_RX_WR, S_DESEL, S_FIN
    } state_t;

    state_t     state, nxt;
    logic [5:0] idx, last;
    logic [6:0] len_c;
    logic       accept;
    logic       poll_expired;

    assign accept = (state == S_IDLE) && start && (len != 7'd0);
    assign len_c  = (len > 7'(MAX_LEN)) ? 7'(MAX_LEN) : len;

`ifdef SPI_BURST_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic        err_q;
    logic        timeout_hit;

    assign poll_expired = (poll_cnt == TIMEOUT);
    assign timeout_hit  = poll_expired &&
                          (((state == S_PT_CHK) && !bus.O_RDATA[TRDY_BIT]) ||
                           ((state == S_PR_CHK) && !bus.O_RDATA[RRDY_BIT]));
    assign err = err_q;

    // The cycle before each poll loop clears the count; each status read bumps it.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            poll_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_FETCH_W || state == S_WR_TX)
                poll_cnt <= '0;
            else if (state == S_PT_RD || state == S_PR_RD)
                poll_cnt <= poll_cnt + 16'd1;
            if (accept)
                err_q <= 1'b0;
            else if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign poll_expired = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge I_CLK) begin
        if (I_RESET) state <= S_IDLE;
        else         state <= nxt;
    end

    // last holds L-1 so a 64-byte burst never needs a 7-bit compare.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            idx  <= '0;
            last <= '0;
        end else if (accept) begin
            idx  <= '0;
            last <= 6'(len_c - 7'd1);
        end else if (state == S_RX_WR && idx != last) begin
            idx <= idx + 6'd1;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (start) nxt = (len == 7'd0) ? S_ZERO : S_SEL;
            S_ZERO:    nxt = S_IDLE;
            S_SEL:     nxt = S_FETCH;
            S_FETCH:   nxt = S_FETCH_W;
            S_FETCH_W: nxt = S_PT_RD;
            S_PT_RD:   nxt = S_PT_CHK;
            S_PT_CHK:  if (bus.O_RDATA[TRDY_BIT]) nxt = S_WR_TX;
                       else if (poll_expired)     nxt = S_DESEL;
                       else                       nxt = S_PT_RD;
            S_WR_TX:   nxt = S_PR_RD;
            S_PR_RD:   nxt = S_PR_CHK;
            S_PR_CHK:  if (bus.O_RDATA[RRDY_BIT]) nxt = S_RX_RD;
                       else if (poll_expired)     nxt = S_DESEL;
                       else                       nxt = S_PR_RD;
            S_RX_RD:   nxt = S_RX_WR;
            S_RX_WR:   nxt = (idx == last) ? S_DESEL : S_FETCH;
            S_DESEL:   nxt = S_FIN;
            S_FIN:     nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.I_TX_EN = 1'b0;
        bus.I_WADDR = '0;
        bus.I_WDATA = '0;
        bus.I_RX_EN = 1'b0;
        bus.I_RADDR = '0;
        bus.rx_we   = 1'b0;
        bus.rx_byte = '0;
        case (state)
            S_SEL: begin
                bus.I_TX_EN = 1'b1;
                bus.I_WADDR = ADDR_SSMASK;
                bus.I_WDATA = DATA_WIDTH'(1);
            end
            S_PT_RD, S_PR_RD: begin
                bus.I_RX_EN = 1'b1;
                bus.I_RADDR = ADDR_STATUS;
            end
            S_WR_TX: begin
                bus.I_TX_EN = 1'b1;
                bus.I_WADDR = ADDR_TXDATA;
                bus.I_WDATA = bus.tx_byte;
            end
            S_RX_RD: begin
                bus.I_RX_EN = 1'b1;
                bus.I_RADDR = ADDR_RXDATA;
            end
            S_RX_WR: begin
                bus.rx_we   = 1'b1;
                bus.rx_byte = bus.O_RDATA;
            end
            S_DESEL: begin
                bus.I_TX_EN = 1'b1;
                bus.I_WADDR = ADDR_SSMASK;
                bus.I_WDATA = '0;
            end
            default: ;
        endcase
    end

    // The buffer read address is held at idx so tx_byte stays valid through WR_TX.
    assign bus.tx_addr = idx;
    assign bus.rx_addr = idx;
    assign busy = (state != S_IDLE) && (state != S_ZERO) && (state != S_FIN);
    assign done = (state == S_FIN) || (state == S_ZERO);
endmodule

// File: tb/tb_m_spi_burst_ctrl.sv
// Randomized bench for m_spi_burst_ctrl: SPI master/buffer responder plus a burst-level
// reference model (write list, receive list, cycle and status-read counts).
module tb_m_spi_burst_ctrl;
    localparam logic [2:0] A_RX = 3'd0, A_TX = 3'd1, A_ST = 3'd2, A_SS = 3'd4;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [6:0] len = '0;
    logic       busy, done, err;

    m_spi_burst_ctrl_if bus();
    m_spi_burst_ctrl #(.TIMEOUT(16'd8)) dut (
        .I_CLK(clk), .I_RESET(rst), .start(start), .len(len),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    logic [7:0] txbuf [64];
    int         stall_t [64];
    int         stall_r [64];

    // Responder: outgoing buffer with one-cycle read, SPI master echoing TX xor FF.
    logic [7:0] last_tx = '0;
    logic       rphase = 1'b0;
    int         pollcnt = 0, bn = 0;

    function automatic logic [7:0] status_word(input logic rp, input int pc, input int b);
        logic [7:0] s;
        s = 8'($urandom);
        s[5] = 1'b0;
        s[7] = 1'b0;
        if (!rp) s[5] = (pc >= stall_t[b % 64]);
        else     s[7] = (pc >= stall_r[b % 64]);
        return s;
    endfunction

    always @(posedge clk) begin
        bus.tx_byte <= txbuf[bus.tx_addr];
        if (bus.I_TX_EN && bus.I_WADDR == A_SS) begin
            rphase <= 1'b0; pollcnt <= 0; bn <= 0;
        end else if (bus.I_TX_EN && bus.I_WADDR == A_TX) begin
            last_tx <= bus.I_WDATA; rphase <= 1'b1; pollcnt <= 0;
        end
        if (bus.I_RX_EN && bus.I_RADDR == A_ST) begin
            bus.O_RDATA <= status_word(rphase, pollcnt, bn);
            pollcnt <= pollcnt + 1;
        end else if (bus.I_RX_EN && bus.I_RADDR == A_RX) begin
            bus.O_RDATA <= last_tx ^ 8'hFF;
            rphase <= 1'b0; pollcnt <= 0; bn <= bn + 1;
        end else begin
            bus.O_RDATA <= 8'($urandom);
        end
    end

    // Monitor: captures register writes, buffer writes and per-cycle counts.
    logic [10:0] wq [$];
    logic [13:0] rq [$];
    int nstat = 0, nrxen = 0, ndone = 0, nbusy = 0, nboth = 0;

    always @(negedge clk) begin
        if (bus.I_TX_EN) wq.push_back({bus.I_WADDR, bus.I_WDATA});
        if (bus.I_RX_EN) nrxen++;
        if (bus.I_RX_EN && bus.I_RADDR == A_ST) nstat++;
        if (bus.I_TX_EN && bus.I_RX_EN) nboth++;
        if (bus.rx_we) rq.push_back({bus.rx_addr, bus.rx_byte});
        if (done) ndone++;
        if (busy) nbusy++;
    end

    // Reference model: what a burst of length l must produce.
    logic [10:0] ew [$];
    logic [13:0] er [$];
    int ebusy, estat;

    task automatic model(input int l);
        int n, s;
        n = (l > 64) ? 64 : l;
        s = 0;
        ew.delete(); er.delete();
        ew.push_back({A_SS, 8'h01});
        for (int i = 0; i < n; i++) begin
            ew.push_back({A_TX, txbuf[i]});
            er.push_back({6'(i), txbuf[i] ^ 8'hFF});
            s += stall_t[i] + stall_r[i];
        end
        ew.push_back({A_SS, 8'h00});
        ebusy = 2 + 9 * n + 2 * s;
        estat = 2 * n + s;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic clr();
        wq.delete(); rq.delete();
        nstat = 0; nrxen = 0; ndone = 0; nbusy = 0; nboth = 0;
    endtask

    task automatic pulse(input int l);
        start = 1'b1; len = 7'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (ndone != 0) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic no_stalls();
        for (int i = 0; i < 64; i++) begin stall_t[i] = 0; stall_r[i] = 0; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        vectors++;
        if ({bus.I_TX_EN, bus.I_RX_EN, bus.rx_we, busy, done, err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {bus.I_TX_EN, bus.I_RX_EN, bus.rx_we, busy, done, err});
        end
        vectors++;
        if ({bus.tx_addr, bus.rx_addr, bus.rx_byte, bus.I_WADDR, bus.I_WDATA, bus.I_RADDR} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_buses: got %h want 0",
                     {bus.tx_addr, bus.rx_addr, bus.rx_byte, bus.I_WADDR, bus.I_WDATA, bus.I_RADDR});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_master();
        bit ok;
        int bad;
        logic [7:0] msg [6];
        msg = '{8'h4D, 8'h41, 8'h53, 8'h54, 8'h45, 8'h52};
        for (int i = 0; i < 6; i++) txbuf[i] = msg[i];
        no_stalls(); clr(); model(6);
        pulse(6);
        vectors++;
        if (nbusy !== 1) begin miscompares++; $display("FAIL master_busy_rise: got %0d want 1", nbusy); end
        wait_done(300, ok);
        tick(3);
        vectors++;
        if (!ok || ndone !== 1) begin miscompares++; $display("FAIL master_done: got %0d want 1", ndone); end
        bad = (wq.size() == ew.size()) ? 0 : 1;
        for (int i = 0; i < wq.size() && i < ew.size(); i++) if (wq[i] !== ew[i]) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL master_writes: got %0d writes, %0d bad, want %0d", wq.size(), bad, ew.size()); end
        bad = (rq.size() == er.size()) ? 0 : 1;
        for (int i = 0; i < rq.size() && i < er.size(); i++) if (rq[i] !== er[i]) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL master_rx: got %0d entries, %0d bad, want %0d", rq.size(), bad, er.size()); end
        vectors++;
        if (rq.size() != 6 || rq[5] !== {6'd5, 8'hAD}) begin
            miscompares++; $display("FAIL master_last_rx: got %0d entries want addr 5 data AD", rq.size());
        end
        vectors++;
        if (nbusy !== ebusy || nstat !== estat || nboth !== 0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL master_timing: busy %0d/%0d stat %0d/%0d both %0d err %b (got/want, want both 0 err 0)",
                     nbusy, ebusy, nstat, estat, nboth, err);
        end
    endtask

    task automatic test_zero_len();
        tick(); clr();
        pulse(0);
        vectors++;
        if (ndone !== 1) begin miscompares++; $display("FAIL zero_done_latency: got %0d want 1", ndone); end
        tick(5);
        vectors++;
        if (ndone !== 1 || wq.size() != 0 || nrxen !== 0 || nbusy !== 0) begin
            miscompares++;
            $display("FAIL zero_quiet: done %0d writes %0d reads %0d busy %0d want 1 0 0 0",
                     ndone, wq.size(), nrxen, nbusy);
        end
    endtask

    task automatic test_clamp();
        bit ok;
        int bad, ntx;
        for (int i = 0; i < 64; i++) txbuf[i] = 8'($urandom);
        no_stalls(); clr(); model(100);
        pulse(100);
        wait_done(2000, ok);
        tick(2);
        ntx = 0;
        foreach (wq[i]) if (wq[i][10:8] == A_TX) ntx++;
        vectors++;
        if (!ok || ntx != 64) begin miscompares++; $display("FAIL clamp_tx_count: got %0d want 64", ntx); end
        bad = (rq.size() == er.size()) ? 0 : 1;
        for (int i = 0; i < rq.size() && i < er.size(); i++) if (rq[i] !== er[i]) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL clamp_rx: got %0d entries, %0d bad, want 64", rq.size(), bad); end
        vectors++;
        if (rq.size() == 0 || rq[rq.size()-1][13:8] !== 6'd63) begin
            miscompares++; $display("FAIL clamp_last_addr: got %0d entries want last addr 63", rq.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        for (int i = 0; i < 64; i++) txbuf[i] = 8'($urandom);
        no_stalls(); stall_r[1] = 20;
        tick(); clr(); model(6);
        pulse(6);
        for (int c = 0; c < 200 && wq.size() < 3; c++) tick();
        tick(10);
        vectors++;
        if (wq.size() != 3) begin miscompares++; $display("FAIL stall_hold: got %0d writes want 3", wq.size()); end
        pulse(3);
        wait_done(1000, ok);
        tick(2);
        bad = (wq.size() == ew.size()) ? 0 : 1;
        for (int i = 0; i < wq.size() && i < ew.size(); i++) if (wq[i] !== ew[i]) bad++;
        for (int i = 0; i < rq.size() && i < er.size(); i++) if (rq[i] !== er[i]) bad++;
        if (rq.size() != er.size()) bad++;
        vectors++;
        if (!ok || bad != 0) begin miscompares++; $display("FAIL stall_result: %0d bad entries want 0", bad); end
        vectors++;
        if (ndone !== 1 || nbusy !== ebusy) begin
            miscompares++; $display("FAIL stall_cycles: done %0d busy %0d want 1 %0d", ndone, nbusy, ebusy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        no_stalls(); stall_r[3] = 30;
        tick(); clr();
        pulse(6);
        for (int c = 0; c < 300 && wq.size() < 5; c++) tick();
        tick(4);
        rst = 1'b1;
        tick();
        vectors++;
        if ({bus.I_TX_EN, bus.I_RX_EN, bus.rx_we, busy, done, err, bus.tx_addr, bus.rx_addr, bus.rx_byte} !== 26'h0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h want 0",
                     {bus.I_TX_EN, bus.I_RX_EN, bus.rx_we, busy, done, err, bus.tx_addr, bus.rx_addr, bus.rx_byte});
        end
        vectors++;
        if (wq.size() != 5 || ndone !== 0) begin
            miscompares++; $display("FAIL midreset_nodesel: writes %0d done %0d want 5 0", wq.size(), ndone);
        end
        rst = 1'b0;
        no_stalls();
        tick(); clr(); model(2);
        pulse(2);
        wait_done(300, ok);
        tick(2);
        bad = (wq.size() == ew.size() && rq.size() == er.size()) ? 0 : 1;
        for (int i = 0; i < wq.size() && i < ew.size(); i++) if (wq[i] !== ew[i]) bad++;
        for (int i = 0; i < rq.size() && i < er.size(); i++) if (rq[i] !== er[i]) bad++;
        vectors++;
        if (!ok || bad != 0 || ndone !== 1) begin
            miscompares++; $display("FAIL midreset_recover: %0d bad, done %0d want 0 1", bad, ndone);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int bad, l;
        for (int it = 0; it < 8; it++) begin
            l = $urandom_range(1, 80);
            for (int i = 0; i < 64; i++) begin
                txbuf[i]   = 8'($urandom);
                stall_t[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                stall_r[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            tick(); clr(); model(l);
            pulse(l);
            wait_done(3000, ok);
            bad = (wq.size() == ew.size() && rq.size() == er.size()) ? 0 : 1;
            for (int i = 0; i < wq.size() && i < ew.size(); i++) if (wq[i] !== ew[i]) bad++;
            for (int i = 0; i < rq.size() && i < er.size(); i++) if (rq[i] !== er[i]) bad++;
            vectors++;
            if (!ok || bad != 0) begin
                miscompares++; $display("FAIL rand_%0d_data: len %0d, %0d bad entries want 0", it, l, bad);
            end
            vectors++;
            if (nbusy !== ebusy || nstat !== estat || nboth !== 0 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_%0d_timing: busy %0d/%0d stat %0d/%0d both %0d err %b", it, nbusy, ebusy, nstat, estat, nboth, err);
            end
        end
    endtask

`ifdef SPI_BURST_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        no_stalls(); stall_t[0] = 1000;
        tick(); clr();
        pulse(4);
        wait_done(500, ok);
        tick();
        vectors++;
        if (!ok || nstat !== 8 || rq.size() != 0 || err !== 1'b1) begin
            miscompares++; $display("FAIL timeout_abort: reads %0d rx %0d err %b want 8 0 1", nstat, rq.size(), err);
        end
        vectors++;
        if (wq.size() != 2 || wq[wq.size()-1] !== {A_SS, 8'h00}) begin
            miscompares++; $display("FAIL timeout_desel: got %0d writes want 2 ending SSMASK 00", wq.size());
        end
        no_stalls(); clr();
        pulse(1);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL timeout_err_clear: got %b want 0", err); end
        wait_done(300, ok);
    endtask
`endif

    initial begin
        no_stalls();
        for (int i = 0; i < 64; i++) txbuf[i] = '0;
        test_reset();
        test_master();
        test_zero_len();
        test_clamp();
        test_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef SPI_BURST_TIMEOUT_EN
        test_timeout();
`endif
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
